// File: rtl/prll_bs_rbtr_riscv_pkg.sv
// Shared types and helpers for the round-robin bus arbiter.
// Arbiter FSM encoding, requester ceiling, and modular pointer walk.
package prll_bus_pkg;

   localparam int MAX_DRVRS = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      TURN = 2'd2
   } state_e;

   // (p + k) mod n for p < n, k < n, without a divider
   function automatic int rr_wrap(input int p, input int k, input int n);
      return (p + k >= n) ? (p + k - n) : (p + k);
   endfunction

endpackage

// File: rtl/prll_bs_rbtr_riscv_if.sv
// Bus-arbitration signal bundle between requesters (master) and arbiter (slave).
interface prll_bs_rbtr_riscv_if #(
   parameter int drvrs = 3
);
   localparam int IW = $clog2(drvrs);

   logic [drvrs-1:0] req;
   logic [drvrs-1:0] done;
   logic [drvrs-1:0] grnt;
   logic [IW-1:0]    grnt_id;
   logic             bs_busy;
   logic             trn_chng;
   logic             tmout;

   modport master (
      output req, done,
      input  grnt, grnt_id, bs_busy, trn_chng, tmout
   );

   modport slave (
      input  req, done,
      output grnt, grnt_id, bs_busy, trn_chng, tmout
   );

endinterface

// File: rtl/prll_bs_rbtr_riscv_rr_pckr.sv
// Combinational round-robin picker: first requester at or after i_ptr,
// searching upward modulo N; one-hot winner, binary index and any-flag.
module rr_pckr
   import prll_bus_pkg::*;
#(
   parameter int N  = 3,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_ptr,
   output logic [N-1:0]  o_win,
   output logic [IW-1:0] o_idx,
   output logic          o_any
);

   // Walk offsets from farthest to nearest so the nearest hit overwrites last
   always_comb begin
      o_win = '0;
      o_idx = '0;
      o_any = 1'b0;
      for (int k = N - 1; k >= 0; k--) begin
         if (i_req[IW'(rr_wrap(int'(i_ptr), k, N))]) begin
            o_win = '0;
            o_win[IW'(rr_wrap(int'(i_ptr), k, N))] = 1'b1;
            o_idx = IW'(rr_wrap(int'(i_ptr), k, N));
            o_any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/prll_bs_rbtr_riscv.sv
// Round-robin bus arbiter with registered one-hot grant and a turnaround cycle
// between owners. Hold watchdog compiled in by defining PRLL_RBTR_TMOUT_EN.
module prll_bs_rbtr_riscv
   import prll_bus_pkg::*;
#(
   parameter int drvrs    = 3,
   parameter int max_hold = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   prll_bs_rbtr_riscv_if.slave  bus
);

   localparam int IW = $clog2(drvrs);

   state_e           r_state, w_nxt;
   logic [drvrs-1:0] r_grnt;
   logic [IW-1:0]    r_grnt_id;
   logic [IW-1:0]    r_ptr;
   logic             r_busy;
   logic             r_trn;

   logic [drvrs-1:0] w_win;
   logic [IW-1:0]    w_idx;
   logic             w_any;
   logic             w_rel;
   logic             w_force;

   rr_pckr #(.N(drvrs), .IW(IW)) u_pckr (
      .i_req (bus.req),
      .i_ptr (r_ptr),
      .o_win (w_win),
      .o_idx (w_idx),
      .o_any (w_any)
   );

   // Only the current owner's done/req matter; other done bits are ignored
   assign w_rel = bus.done[r_grnt_id] | ~bus.req[r_grnt_id];

`ifdef PRLL_RBTR_TMOUT_EN
   logic [7:0] r_hold_cnt;
   logic       r_tmout;

   assign w_force = (r_hold_cnt == 8'(max_hold - 1));

   // Zero outside HOLD, so it reads 0 on the first HOLD cycle
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_hold_cnt <= '0;
         r_tmout    <= 1'b0;
      end else begin
         r_tmout <= (r_state == HOLD) && !w_rel && w_force;
         if (r_state != HOLD)
            r_hold_cnt <= '0;
         else if (r_hold_cnt != 8'hFF)
            r_hold_cnt <= r_hold_cnt + 8'd1;
      end
   end

   assign bus.tmout = r_tmout;
`else
   assign w_force   = 1'b0;
   assign bus.tmout = 1'b0;
`endif

   always_comb begin
      w_nxt = r_state;
      case (r_state)
         IDLE:    if (w_any) w_nxt = HOLD;
         HOLD:    if (w_rel || w_force) w_nxt = TURN;
         TURN:    w_nxt = w_any ? HOLD : IDLE;
         default: w_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= IDLE;
         r_grnt    <= '0;
         r_grnt_id <= '0;
         r_ptr     <= '0;
         r_busy    <= 1'b0;
         r_trn     <= 1'b0;
      end else begin
         r_state <= w_nxt;
         r_trn   <= 1'b0;
         case (r_state)
            IDLE, TURN: begin
               if (w_any) begin
                  r_grnt    <= w_win;
                  r_grnt_id <= w_idx;
                  r_busy    <= 1'b1;
               end
            end
            HOLD: begin
               // Pointer moves past the owner before TURN so it loses ties there
               if (w_rel || w_force) begin
                  r_grnt <= '0;
                  r_busy <= 1'b0;
                  r_trn  <= 1'b1;
                  r_ptr  <= (r_grnt_id == IW'(drvrs - 1)) ? '0 : r_grnt_id + 1'b1;
               end
            end
            default: begin
               r_grnt <= '0;
               r_busy <= 1'b0;
            end
         endcase
      end
   end

   assign bus.grnt     = r_grnt;
   assign bus.grnt_id  = r_grnt_id;
   assign bus.bs_busy  = r_busy;
   assign bus.trn_chng = r_trn;

endmodule

// File: doc/prll_bs_rbtr_riscv.md
PRLL_BS_RBTR_RISCV -- requirements
Module: prll_bs_rbtr_riscv

Interface
REQ-001 Parameter drvrs, default 3, number of bus requesters (2..8).
REQ-002 Parameter max_hold, default 16, maximum cycles one owner may hold the bus (4..255).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req  input  drvrs  per-requester bus request, level, held until granted and done.
REQ-006 done  input  drvrs  per-requester single-cycle release strobe, valid only from current owner.
REQ-007 grnt  output  drvrs  one-hot registered bus grant; all-zero when bus not owned.
REQ-008 grnt_id  output  $clog2(drvrs)  binary index of current or last owner.
REQ-009 bs_busy  output  1  high while any grnt bit high.
REQ-010 trn_chng  output  1  one-cycle pulse in the turnaround cycle after every release.
REQ-011 tmout  output  1  one-cycle pulse when a grant is revoked by the hold watchdog.

Function
REQ-012 FSM states SHALL be IDLE, HOLD, TURN; no other encodings reachable.
REQ-013 IDLE: any req bit high -> HOLD next cycle with grnt of the round-robin winner; no req -> stay IDLE.
REQ-014 Winner SHALL be the first requester at or after pointer rr_ptr, searching upward modulo drvrs.
REQ-015 Grant latency SHALL be exactly one cycle from req sampled high in IDLE to grnt high.
REQ-016 HOLD: done[owner] high, or req[owner] low -> TURN; grnt clears in the same transition.
REQ-017 done from a non-owner SHALL be ignored; done while IDLE or TURN SHALL be ignored.
REQ-018 TURN lasts exactly one cycle, grnt all-zero, trn_chng high, rr_ptr <- (owner+1) mod drvrs.
REQ-019 TURN -> HOLD with new winner if any req high, else -> IDLE; no back-to-back grant without TURN.
REQ-020 An owner re-requesting in TURN SHALL win only if no other requester is high (fairness).
REQ-021 grnt_id SHALL retain the last owner in IDLE and TURN; bs_busy equals OR of grnt.
REQ-022 Hold counter SHALL be 8 bits, clear on HOLD entry, increment each HOLD cycle, saturate at 255.

Reset
REQ-023 On reset low: state IDLE, grnt 0, grnt_id 0, bs_busy 0, trn_chng 0, tmout 0, rr_ptr 0, hold counter 0.
REQ-024 Reset asserted mid-HOLD SHALL drop grnt immediately (asynchronous), with no trn_chng pulse.
REQ-025 First grant after reset release SHALL favour requester 0 when several request.

Configuration
REQ-026 Macro PRLL_RBTR_TMOUT_EN SHALL compile in the hold watchdog.
REQ-027 With PRLL_RBTR_TMOUT_EN: hold counter reaching max_hold-1 in HOLD forces TURN, tmout pulses with trn_chng.
REQ-028 Without PRLL_RBTR_TMOUT_EN: no forced release, tmout tied 0, hold counter absent.

Structure
REQ-029 Package prll_bus_pkg SHALL hold the FSM state enum (IDLE, HOLD, TURN) and MAX_DRVRS = 8.
REQ-030 Sub-module rr_pckr (combinational round-robin picker: req, rr_ptr -> one-hot winner, index, any).
REQ-031 All outputs SHALL be registered; no combinational path from req/done to grnt.

Verification
REQ-032 Reset low then high, req=3'b111 -> grnt=3'b001 one cycle later, grnt_id=0, bs_busy=1.
REQ-033 Owner 0 strobes done, req=3'b111 kept -> one TURN cycle (grnt=0, trn_chng=1), then grnt=3'b010, then 3'b100, then 3'b001.
REQ-034 req=3'b010 only, done at cycle 5 -> grnt 3'b010 cycles 1-5, TURN cycle 6, IDLE cycle 7, grnt_id stays 1.
REQ-035 Owner 1 granted, done[2] pulsed -> ignored, grnt stays 3'b010.
REQ-036 With PRLL_RBTR_TMOUT_EN, max_hold=16, owner never strobes done -> grnt drops after 16 HOLD cycles, tmout=1 and trn_chng=1 same cycle.
REQ-037 reset driven low mid-HOLD -> grnt=0 asynchronously, trn_chng stays 0, next grant goes to requester 0.
